// File: rtl/if_id_fetch_stage_pkg.sv
// Pipeline constants shared by the fetch, decode and hazard blocks.
package if_id_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_id_fetch_stage_pc_register.sv
// Program counter with hold, redirect (word-aligned target) and PC+4 increment.
module if_id_fetch_stage_pc_register
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_d, pc_q;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_INC;

    always_comb begin
        pc_d = pc_plus4_o;
        if (redirect_i) begin
            // Misaligned targets are silently forced onto a word boundary.
            pc_d = target_i & ~32'h0000_0003;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// MIPS fetch stage: PC, IF/ID pipeline register and saturating stall counter.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Stall,
    input  logic                   Redirect,
    input  logic [31:0]            RedirectTarget,
    input  logic [31:0]            IMemInstr,
    output logic [31:0]            IMemAddr,
    output logic [31:0]            IF_ID_Instr,
    output logic [31:0]            IF_ID_PCPlus4,
    output logic                   IF_ID_Valid,
    output logic [4:0]             IF_ID_Rs,
    output logic [4:0]             IF_ID_Rt,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic [31:0]            pc, pc_plus4;
    logic [31:0]            instr_d, instr_q;
    logic [31:0]            pcp4_d, pcp4_q;
    logic                   valid_d, valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    if_id_fetch_stage_pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .hold_i    (Stall),
        .redirect_i(Redirect),
        .target_i  (RedirectTarget),
        .pc_o      (pc),
        .pc_plus4_o(pc_plus4)
    );

    always_comb begin
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (Redirect) begin
            // Redirect wins over stall: the stalled wrong-path instruction is dropped.
            instr_d = NOP_INSTR;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (Stall) begin
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            instr_d = IMemInstr;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            instr_q     <= NOP_INSTR;
            pcp4_q      <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IMemAddr      = pc;
    assign IF_ID_Instr   = instr_q;
    assign IF_ID_PCPlus4 = pcp4_q;
    assign IF_ID_Valid   = valid_q;
    assign IF_ID_Rs      = instr_q[RS_MSB:RS_LSB];
    assign IF_ID_Rt      = instr_q[RT_MSB:RT_LSB];
    assign StallCount    = stall_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed testbench for if_id_fetch_stage with hand-computed expectations.
module tb_if_id_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'h0;
    logic [31:0] IMemInstr;
    logic [31:0] IMemAddr;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;
    logic [3:0]  StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_fetch_stage #(
        .RESET_PC   (32'h0000_0100),
        .STALL_CNT_W(4)
    ) u_dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectTarget(RedirectTarget),
        .IMemInstr     (IMemInstr),
        .IMemAddr      (IMemAddr),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .StallCount    (StallCount)
    );

    always #5 Clk = ~Clk;

    // Small instruction ROM model.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h012A_4020;
            32'h0000_0104: return 32'h8D28_0004;
            32'h0000_0108: return 32'h8D2A_0008;
            default:       return {16'hDEAD, addr[15:0]};
        endcase
    endfunction

    assign IMemInstr = imem(IMemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, IMemAddr, 32'h100);
        check({tag, "_valid"}, {31'h0, IF_ID_Valid}, 32'h0);
        check({tag, "_instr"}, IF_ID_Instr, 32'h0);
        check({tag, "_pcp4"}, IF_ID_PCPlus4, 32'h0);
        check({tag, "_cnt"}, {28'h0, StallCount}, 32'h0);
    endtask

    initial begin
        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        #2 Rst = 1'b1;
        #1 check_reset_state("rst_async");
        step();
        step();
        @(negedge Clk);
        Rst = 1'b0;

        step();
        check("fetch0_instr", IF_ID_Instr, 32'h012A_4020);
        check("fetch0_rs", {27'h0, IF_ID_Rs}, 32'd9);
        check("fetch0_rt", {27'h0, IF_ID_Rt}, 32'd10);
        check("fetch0_pcp4", IF_ID_PCPlus4, 32'h104);
        check("fetch0_addr", IMemAddr, 32'h104);
        check("fetch0_valid", {31'h0, IF_ID_Valid}, 32'h1);

        step();
        check("fetch1_instr", IF_ID_Instr, 32'h8D28_0004);
        check("fetch1_addr", IMemAddr, 32'h108);

        // Three-cycle stall holds PC and IF/ID.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("stall_addr", IMemAddr, 32'h108);
        check("stall_instr", IF_ID_Instr, 32'h8D28_0004);
        check("stall_pcp4", IF_ID_PCPlus4, 32'h108);
        check("stall_cnt", {28'h0, StallCount}, 32'd3);

        Stall = 1'b0;
        step();
        check("resume_instr", IF_ID_Instr, 32'h8D2A_0008);
        check("resume_pcp4", IF_ID_PCPlus4, 32'h10C);
        check("resume_addr", IMemAddr, 32'h10C);
        check("resume_cnt", {28'h0, StallCount}, 32'd3);

        // Redirect beats stall; target low bits cleared.
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0203;
        Stall = 1'b1;
        step();
        check("redir_addr", IMemAddr, 32'h200);
        check("redir_valid", {31'h0, IF_ID_Valid}, 32'h0);
        check("redir_instr", IF_ID_Instr, 32'h0);
        check("redir_pcp4", IF_ID_PCPlus4, 32'h0);
        check("redir_cnt", {28'h0, StallCount}, 32'd3);

        // Back-to-back redirect loads the new target, IF/ID stays flushed.
        Stall = 1'b0;
        RedirectTarget = 32'hFFFF_FFFE;
        step();
        check("redir2_addr", IMemAddr, 32'hFFFF_FFFC);
        check("redir2_valid", {31'h0, IF_ID_Valid}, 32'h0);

        // PC wraps modulo 2^32.
        Redirect = 1'b0;
        step();
        check("wrap_addr", IMemAddr, 32'h0);
        check("wrap_pcp4", IF_ID_PCPlus4, 32'h0);
        check("wrap_valid", {31'h0, IF_ID_Valid}, 32'h1);
        check("wrap_instr", IF_ID_Instr, 32'hDEAD_FFFC);

        // Stall still holds while IF/ID is invalid.
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0300;
        step();
        Redirect = 1'b0;
        Stall = 1'b1;
        step();
        check("stall_inv_valid", {31'h0, IF_ID_Valid}, 32'h0);
        check("stall_inv_addr", IMemAddr, 32'h300);
        check("stall_inv_cnt", {28'h0, StallCount}, 32'd4);

        // Saturation of the 4-bit counter; PC never moves.
        for (int i = 0; i < 20; i++) begin
            step();
            check("sat_addr", IMemAddr, 32'h300);
        end
        check("sat_cnt", {28'h0, StallCount}, 32'hF);

        // Redirect on the edge right after the stall releases.
        Stall = 1'b0;
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0400;
        step();
        check("post_stall_redir_addr", IMemAddr, 32'h400);
        check("post_stall_redir_cnt", {28'h0, StallCount}, 32'hF);
        Redirect = 1'b0;

        // Rebuild a count of 5, then reset asynchronously mid-stall.
        @(negedge Clk);
        Rst = 1'b1;
        #1 check_reset_state("rst_sync");
        @(negedge Clk);
        Rst = 1'b0;
        step();
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_cnt", {28'h0, StallCount}, 32'd5);
        check("pre_rst_addr", IMemAddr, 32'h104);
        #2 Rst = 1'b1;
        #1 check_reset_state("rst_mid_stall");
        @(negedge Clk);
        Stall = 1'b0;
        Rst = 1'b0;
        step();
        check("refetch_instr", IF_ID_Instr, 32'h012A_4020);
        check("refetch_pcp4", IF_ID_PCPlus4, 32'h104);
        check("refetch_addr", IMemAddr, 32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline: program counter, PC+4 adder, redirect mux, and the IF/ID pipeline register.
- Drives the instruction-memory address, captures the returned instruction, and presents Rs/Rt fields to the hazard detection unit.
- Consumes that unit's flush/stall decision: holds PC and IF/ID while ID is being re-issued as a nop.
- Consumes branch/jump redirects resolved in a later stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Stall  input  1  from hazard unit; 1 = hold PC and IF/ID this cycle.
- Redirect  input  1  taken branch/jump resolved downstream.
- RedirectTarget  input  32  next-fetch address when Redirect=1.
- IMemInstr  input  32  instruction read combinationally at IMemAddr.
- IMemAddr  output  32  current PC to instruction memory.
- IF_ID_Instr  output  32  registered instruction for decode.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  1 = IF_ID_Instr is a real fetched instruction.
- IF_ID_Rs  output  5  IF_ID_Instr[25:21], to hazard unit.
- IF_ID_Rt  output  5  IF_ID_Instr[20:16], to hazard unit.
- StallCount  output  STALL_CNT_W  saturating count of cycles with Stall=1 and Redirect=0.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - PC=RESET_PC; IF_ID_Instr=32'h0 (nop); IF_ID_PCPlus4=0; IF_ID_Valid=0; StallCount=0.
  - First edge after Rst deasserts fetches RESET_PC.
- IMemAddr = PC, combinational from the PC register. IF_ID_Rs/IF_ID_Rt are combinational slices of the IF_ID_Instr register.
- Per-edge priority (highest first):
  - Redirect=1:
    - PC <= {RedirectTarget[31:2],2'b00}; low two bits are silently cleared.
    - IF/ID flushed: Instr=0, PCPlus4=0, Valid=0.
    - Stall is ignored that cycle and StallCount does not increment; the wrong-path instruction being stalled is discarded.
  - Stall=1:
    - PC, IF_ID_Instr, IF_ID_PCPlus4 and IF_ID_Valid all hold.
    - IMemInstr is ignored.
    - StallCount increments, saturating at all-ones; no wrap.
  - Otherwise:
    - PC <= PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
    - IF_ID_Instr <= IMemInstr; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1.
- Latency: an instruction at address A appears on IF_ID_* one edge after PC=A with no stall.
- Consecutive stalls of any length hold IF/ID indefinitely. Normal fetch resumes on the first edge with Stall=0.
- A redirect on the edge immediately after a stall releases takes effect normally; there is no stall memory.
- Redirect asserted in consecutive cycles: each edge loads the new target; IF/ID stays flushed.
- Stall while IF_ID_Valid=0 still holds, since the hazard unit does not qualify on valid.
- No X propagation: IMemInstr is sampled only on the normal-fetch path.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR = 32'h0.
  - Field positions RS_MSB/RS_LSB = 25/21 and RT_MSB/RT_LSB = 20/16.
  - PC_INC = 4.
  - These are the same constants the decode and hazard blocks use.
- One natural sub-module, pc_register:
  - Owns the PC register, async reset, hold/redirect/increment mux, and target alignment.
  - Exposes PC and PC+4.
- The IF/ID register and StallCount stay in the top module.

Test Plan:
- Reset with RESET_PC=32'h100: assert Rst mid-cycle → IMemAddr=32'h100, IF_ID_Valid=0, IF_ID_Instr=0, StallCount=0 immediately (asynchronous). Release, supply IMemInstr=32'h012A4020 → next edge IF_ID_Instr=32'h012A4020, IF_ID_Rs=9, IF_ID_Rt=10, IF_ID_PCPlus4=32'h104, IMemAddr=32'h104.
- Stall for 3 cycles at PC=32'h108 with IF_ID holding 32'h8D280004 → IMemAddr stays 32'h108, IF_ID unchanged, StallCount=3. Release → next edge loads the instruction at 32'h108 and IMemAddr=32'h10C.
- Redirect=1, RedirectTarget=32'h0000_0203, Stall=1 on the same edge → IMemAddr=32'h200, IF_ID_Valid=0, IF_ID_Instr=0, StallCount unchanged.
- PC wrap: after Redirect to 32'hFFFF_FFFC, one normal edge → IMemAddr=32'h0, IF_ID_PCPlus4=32'h0, IF_ID_Valid=1.
- StallCount saturation with STALL_CNT_W=4: hold Stall for 20 cycles → StallCount=4'hF, PC unchanged throughout.
- Async reset asserted during a stall with StallCount=5 → all outputs return to reset values without a clock edge. The first fetch after release is from RESET_PC.
